// File: rtl/lfsr_pkg.sv
// lfsr_pkg: PRBS checker state type, common Fibonacci polynomials and the shared prediction helper
package lfsr_pkg;
  typedef enum logic [1:0] {SEED, CHECK, LOCKED} prbs_state_e;
  localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [15:0] PRBS16_TAPS = 16'hB400;
  localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;
  function automatic logic lfsr_fib_pred(input logic [63:0] lfsr, input logic [63:0] taps);
    return ^(lfsr & taps);
  endfunction
endpackage

// File: rtl/prbs_checker_s.sv
// prbs_checker_s: self-synchronising serial PRBS checker with lock detection and saturating error count
module prbs_checker_s
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = PRBS16_TAPS,
  parameter int               LOCK_CNT   = 32,
  parameter int               ERR_THRESH = 8,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_cnt,
  input  logic             din_vld,
  input  logic             din,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int SW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_THRESH + 1);
  prbs_state_e      r_state, w_next;
  logic [WIDTH-1:0] r_lfsr;
  logic [SW-1:0]    r_seed_cnt;
  logic [GW-1:0]    r_good_cnt;
  logic [BW-1:0]    r_bad_run;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_pred, w_match, w_good, w_seed_done, w_lock_done, w_err, w_drop, w_locked;
  assign w_pred      = lfsr_fib_pred(64'(r_lfsr), 64'(TAPS));
  assign w_match     = din == w_pred;
  assign w_good      = w_match && r_lfsr != '0;
  assign w_seed_done = r_seed_cnt == SW'(WIDTH - 1);
  assign w_lock_done = w_good && r_good_cnt == GW'(LOCK_CNT - 1);
  assign w_err       = din_vld && r_state == LOCKED && !w_match;
  assign w_drop      = w_err && r_bad_run == BW'(ERR_THRESH - 1);
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? SEED : w_next;
  // next state: only valid beats move the FSM; a burst of errors forces a resync
  always_comb begin
    w_next = r_state;
    if (din_vld)
      case (r_state)
        SEED:    w_next = w_seed_done ? CHECK : SEED;
        CHECK:   w_next = w_lock_done ? LOCKED : CHECK;
        LOCKED:  w_next = w_drop ? SEED : LOCKED;
        default: w_next = SEED;
      endcase
  end
  // outputs decoded from the registered state
  always_comb
    w_locked = r_state == LOCKED;
  // datapath: the register absorbs din until locked, then free-runs so single errors do not propagate
  always_ff @(posedge clk)
    if (rst) begin
      r_lfsr      <= '0;
      r_seed_cnt  <= '0;
      r_good_cnt  <= '0;
      r_bad_run   <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (clr_cnt) r_err_cnt <= '0;
      else if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      if (din_vld) begin
        r_lfsr     <= {r_lfsr[WIDTH-2:0], r_state == LOCKED ? w_pred : din};
        r_seed_cnt <= r_state == SEED && !w_seed_done ? r_seed_cnt + 1'b1 : '0;
        r_good_cnt <= r_state == CHECK && w_good && !w_lock_done ? r_good_cnt + 1'b1 : '0;
        r_bad_run  <= r_state == LOCKED && !w_match && !w_drop ? r_bad_run + 1'b1 : '0;
      end
    end
  assign locked    = w_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
endmodule
